// File: rtl/afifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbiter.
package afifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF = 8;

  // Index of the set bit; callers guarantee at most one bit is set.
  function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/afifo_rr_picker.sv
// Combinational round-robin picker: rotate past the last winner,
// priority-encode, then rotate the result back into requester space.
module afifo_rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last_winner,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_valid
);

  logic [NREQ-1:0] w_rot;
  int              w_start;
  int              w_pos;

  always_comb begin
    w_rot   = '0;
    w_pos   = 0;
    w_start = int'(i_last_winner) + 1;
    if (w_start >= NREQ) w_start = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_rot[i] = i_req[(w_start + i) % NREQ];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = i;
    end
    o_valid  = |w_rot;
    o_winner = IDX_W'((w_start + w_pos) % NREQ);
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Write-side scheduler sharing one FIFO write port among NREQ requesters
// with round-robin arbitration, burst lock and full-flag backpressure.
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests
// BURST | one requester holds the write port until last, cap or abandon
module afifo_wr_arbiter
  import afifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                     wrclk,
  input  logic                     arst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  input  logic                     wrfull,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     fifo_wr_en,
  output logic [DATA_W-1:0]        fifo_wdata,
  output logic                     busy,
  output logic [15:0]              beat_total
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       r_state, w_state_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_last_winner, w_lw_nxt;
  logic [15:0]      r_beat_total;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_pick;
  logic             w_pick_valid;
  logic             w_busy;
  logic             w_push;
  logic             w_release;

  afifo_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req         (req),
    .i_last_winner (r_last_winner),
    .o_winner      (w_pick),
    .o_valid       (w_pick_valid)
  );

  assign w_busy    = (r_state == BURST);
  assign w_idx     = IDX_W'(onehot2idx(16'(r_gnt)));
  assign w_push    = w_busy & req[w_idx] & ~wrfull;
  // Abandon only counts when the grant is live and the requester has let go.
  assign w_release = (w_push & (req_last[w_idx] | (r_beat_cnt == CNT_LAST)))
                   | (w_busy & ~req[w_idx]);

  assign gnt        = r_gnt;
  assign ack        = w_push ? r_gnt : '0;
  assign fifo_wr_en = w_push;
  assign fifo_wdata = req_data[w_idx*DATA_W +: DATA_W];
  assign busy       = w_busy;
  assign beat_total = r_beat_total;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_beat_cnt;
    w_lw_nxt    = r_last_winner;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = BURST;
          w_gnt_nxt   = NREQ'(1) << w_pick;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (w_release) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_lw_nxt    = w_idx;
          w_cnt_nxt   = '0;
        end else if (w_push) begin
          w_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wrclk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= IDLE;
      r_gnt         <= '0;
      r_beat_cnt    <= '0;
      r_last_winner <= IDX_W'(NREQ - 1);
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_gnt_nxt;
      r_beat_cnt    <= w_cnt_nxt;
      r_last_winner <= w_lw_nxt;
    end
  end

  always_ff @(posedge wrclk or negedge arst_n) begin
    if (!arst_n) begin
      r_beat_total <= '0;
    end else if (w_push && (r_beat_total != 16'hFFFF)) begin
      r_beat_total <= r_beat_total + 16'd1;
    end
  end

  a_gnt_onehot: assert property (@(posedge wrclk) disable iff (!arst_n) $onehot0(gnt));
  a_wr_not_full: assert property (@(posedge wrclk) disable iff (!arst_n) fifo_wr_en |-> !wrfull);

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scenario bench for afifo_wr_arbiter; writes are matched against a queue
// of expected (requester, data) pairs filled as stimulus is planned.
module tb_afifo_wr_arbiter;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic        wrclk = 1'b0;
  logic        arst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        wrfull;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic        busy;
  logic [15:0] beat_total;

  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  int   exp_total = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] mon_ack;

  afifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .wrclk      (wrclk),
    .arst_n     (arst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .wrfull     (wrfull),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .beat_total (beat_total)
  );

  always #5 wrclk = ~wrclk;

  always @(negedge wrclk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write data=%h ack=%b", fifo_wdata, ack);
      end else begin
        mon_e   = sb.pop_front();
        mon_ack = 4'b0001 << mon_e.idx;
        if (fifo_wdata !== mon_e.data || ack !== mon_ack) begin
          errors++;
          $display("FAIL sb_write got data=%h ack=%b expected data=%h ack=%b",
                   fifo_wdata, ack, mon_e.data, mon_ack);
        end
      end
    end
  end

  task automatic tick();
    @(posedge wrclk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [7:0] v);
    req_data[idx*8 +: 8] = v;
  endtask

  task automatic expect_wr(input int idx, input logic [7:0] v);
    exp_t e;
    e.idx  = idx;
    e.data = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    arst_n   = 1'b0;
    req      = '0;
    req_last = '0;
    wrfull   = 1'b0;
    repeat (2) @(negedge wrclk);
    arst_n    = 1'b1;
    exp_total = 0;
  endtask

  task automatic test_reset();
    arst_n   = 1'b0;
    req      = 4'b1111;
    req_last = '0;
    req_data = '0;
    wrfull   = 1'b0;
    repeat (2) @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || fifo_wr_en !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b busy=%b wr_en=%b ack=%b expected all zero",
               gnt, busy, fifo_wr_en, ack);
    end
    checks++;
    if (beat_total !== 16'd0) begin
      errors++;
      $display("FAIL reset_beat_total got=%0d expected=0", beat_total);
    end
    req    = '0;
    arst_n = 1'b1;
  endtask

  task automatic test_single();
    tick();
    req      = 4'b0010;
    req_last = 4'b0010;
    set_data(1, 8'hA5);
    expect_wr(1, 8'hA5);
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_c0_gnt got=%b expected=0000", gnt);
    end
    tick();
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0010 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL single_c1 gnt=%b wr_en=%b expected gnt=0010 wr_en=1", gnt, fifo_wr_en);
    end
    tick();
    req = '0;
    exp_total = exp_total + 1;
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || beat_total !== 16'(exp_total)) begin
      errors++;
      $display("FAIL single_c2 gnt=%b busy=%b total=%0d expected gnt=0000 busy=0 total=%0d",
               gnt, busy, beat_total, exp_total);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int w0;
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) expect_wr(i % 4, 8'h20 + 8'(i % 4));
    w0 = wr_seen;
    tick();
    req      = 4'b1111;
    req_last = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge wrclk);
      exp_g = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL rr_gnt cycle=%0d got=%b expected=%b", c, gnt, exp_g);
      end
      if (c < 9) tick();
    end
    tick();
    req = '0;
    exp_total = exp_total + 5;
    checks++;
    if (wr_seen - w0 != 5) begin
      errors++;
      $display("FAIL rr_write_count got=%0d expected=5", wr_seen - w0);
    end
  endtask

  task automatic test_burst_cap();
    int d2;
    bit d3;
    logic [3:0] a;
    int c;
    for (int i = 0; i < 4; i++) expect_wr(2, 8'h10 + 8'(i));
    expect_wr(3, 8'h30);
    for (int i = 4; i < 8; i++) expect_wr(2, 8'h10 + 8'(i));
    d2 = 0;
    d3 = 0;
    c  = 0;
    tick();
    req      = 4'b1100;
    req_last = 4'b1000;
    set_data(2, 8'h10);
    set_data(3, 8'h30);
    while (c < 40 && !(d2 == 8 && d3)) begin
      @(negedge wrclk);
      a = ack;
      tick();
      if (a[2]) begin
        d2++;
        if (d2 == 8) req[2] = 1'b0;
        else begin
          set_data(2, 8'h10 + 8'(d2));
          req_last[2] = (d2 == 7);
        end
      end
      if (a[3]) begin
        req[3] = 1'b0;
        d3 = 1;
      end
      c++;
    end
    exp_total = exp_total + 9;
    checks++;
    if (!(d2 == 8 && d3)) begin
      errors++;
      $display("FAIL cap_timeout beats2=%0d done3=%0d expected 8 and 1", d2, d3);
    end
    checks++;
    if (sb.size() != 0 || beat_total !== 16'(exp_total)) begin
      errors++;
      $display("FAIL cap_end pending=%0d total=%0d expected pending=0 total=%0d",
               sb.size(), beat_total, exp_total);
    end
  endtask

  task automatic test_backpressure();
    int beats, stall_cyc, c;
    bit stalled;
    logic [3:0] a;
    logic [15:0] saved;
    for (int i = 0; i < 4; i++) expect_wr(0, 8'h40 + 8'(i));
    beats = 0; stall_cyc = 0; stalled = 0; c = 0; saved = '0;
    tick();
    req      = 4'b0001;
    req_last = 4'b0000;
    set_data(0, 8'h40);
    while (c < 40 && beats < 4) begin
      @(negedge wrclk);
      if (wrfull) begin
        stall_cyc++;
        checks++;
        if (fifo_wr_en !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0001 || beat_total !== saved) begin
          errors++;
          $display("FAIL bp_stall wr_en=%b ack=%b gnt=%b total=%0d expected 0 0000 0001 %0d",
                   fifo_wr_en, ack, gnt, beat_total, saved);
        end
      end
      a = ack;
      tick();
      if (a[0]) begin
        beats++;
        if (beats == 4) req[0] = 1'b0;
        else begin
          set_data(0, 8'h40 + 8'(beats));
          req_last[0] = (beats == 3);
        end
      end
      if (wrfull && stall_cyc == 3) wrfull = 1'b0;
      if (beats == 2 && !stalled) begin
        stalled = 1;
        wrfull  = 1'b1;
        saved   = beat_total;
      end
      c++;
    end
    exp_total = exp_total + 4;
    checks++;
    if (beats != 4 || stall_cyc != 3) begin
      errors++;
      $display("FAIL bp_progress beats=%0d stall=%0d expected 4 and 3", beats, stall_cyc);
    end
    checks++;
    if (sb.size() != 0 || beat_total !== 16'(exp_total)) begin
      errors++;
      $display("FAIL bp_end pending=%0d total=%0d expected pending=0 total=%0d",
               sb.size(), beat_total, exp_total);
    end
  endtask

  task automatic test_abandon();
    int w0;
    tick();
    req      = 4'b0010;
    req_last = 4'b1111;
    set_data(2, 8'h55);
    expect_wr(2, 8'h55);
    w0 = wr_seen;
    tick();
    req = 4'b1101;
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0010 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL abandon_grant gnt=%b wr_en=%b expected gnt=0010 wr_en=0", gnt, fifo_wr_en);
    end
    tick();
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || wr_seen != w0) begin
      errors++;
      $display("FAIL abandon_idle gnt=%b busy=%b writes=%0d expected 0000 0 0",
               gnt, busy, wr_seen - w0);
    end
    tick();
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL abandon_next_winner got=%b expected=0100", gnt);
    end
    tick();
    req = '0;
    exp_total = exp_total + 1;
    @(negedge wrclk);
    checks++;
    if (sb.size() != 0 || beat_total !== 16'(exp_total)) begin
      errors++;
      $display("FAIL abandon_end pending=%0d total=%0d expected pending=0 total=%0d",
               sb.size(), beat_total, exp_total);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats, c;
    logic [3:0] a;
    expect_wr(3, 8'h60);
    expect_wr(3, 8'h61);
    beats = 0;
    c = 0;
    tick();
    req      = 4'b1000;
    req_last = 4'b0000;
    set_data(3, 8'h60);
    while (c < 20 && beats < 2) begin
      @(negedge wrclk);
      a = ack;
      tick();
      if (a[3]) begin
        beats++;
        set_data(3, 8'h60 + 8'(beats));
      end
      c++;
    end
    checks++;
    if (beats != 2 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup beats=%0d wr_en=%b expected 2 and 1", beats, fifo_wr_en);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_wr_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_immediate gnt=%b wr_en=%b ack=%b busy=%b expected all zero",
               gnt, fifo_wr_en, ack, busy);
    end
    checks++;
    if (beat_total !== 16'd0) begin
      errors++;
      $display("FAIL rst_beat_total got=%0d expected=0", beat_total);
    end
    req = '0;
    @(negedge wrclk);
    arst_n = 1'b1;
    exp_total = 0;
    tick();
    req      = 4'b1001;
    req_last = 4'b1111;
    set_data(0, 8'h70);
    set_data(3, 8'h71);
    expect_wr(0, 8'h70);
    expect_wr(3, 8'h71);
    tick();
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_priority got=%b expected=0001", gnt);
    end
    tick();
    req[0] = 1'b0;
    tick();
    @(negedge wrclk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rst_second_winner got=%b expected=1000", gnt);
    end
    tick();
    req = '0;
    exp_total = 2;
    @(negedge wrclk);
    checks++;
    if (sb.size() != 0 || beat_total !== 16'(exp_total)) begin
      errors++;
      $display("FAIL rst_end pending=%0d total=%0d expected pending=0 total=%0d",
               sb.size(), beat_total, exp_total);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_abandon();
    test_reset_mid_burst();
    repeat (2) @(negedge wrclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
